// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-master bus arbiter: owner states, master ids,
// and the read-return tag that travels alongside the DRAM read latency.
package bus_arbiter_pkg;

  // Owner state encoding
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  // Master identifiers (also used as last_winner values)
  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  // Read-return tag: {valid, id}
  localparam int TAG_W = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0};

  // Owner state that corresponds to a given master id
  function automatic logic [1:0] owner_of(input logic id);
    return (id == MID_M1) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of both master ports plus the bridge-side bus.
// slave  : the arbiter's view (takes requests, drives grants and the bus).
// master : the environment's view (masters issuing beats, bridge returning data).
interface bus_arbiter_if;

  logic        m0_req;
  logic        m0_lock;
  logic [31:0] m0_addr;
  logic [3:0]  m0_we;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [3:0]  m1_we;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] Bus_addr;
  logic [3:0]  Bus_we;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output Bus_addr, Bus_we, Bus_wdata,
    input  Bus_rdata
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  Bus_addr, Bus_we, Bus_wdata,
    output Bus_rdata
  );

endinterface

// File: rtl/bus_arbiter_rd_return_pipe.sv
// Delays the {valid,id} tag of each read beat by the DRAM read latency so the
// returning Bus_rdata can be steered to the master that issued the read.
// RD_LAT=0 is a straight wire for a combinational DRAM.
module rd_return_pipe
  import bus_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  if (RD_LAT == 0) begin : g_bypass
    assign tag_out = tag_in;
  end else begin : g_pipe
    logic [TAG_W-1:0] stage_r [RD_LAT];

    // Shift tags one stage per cycle; reset discards anything in flight
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < RD_LAT; i++) begin
          stage_r[i] <= TAG_IDLE;
        end
      end else begin
        stage_r[0] <= tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign tag_out = rd_tag_t'(stage_r[RD_LAT-1]);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared Bridge/DRAM bus.
// M0 = CPU data port, M1 = DMA/debug loader. The owner keeps the bus while it
// keeps requesting, hands over directly (no bubble) when the other master is
// waiting and it is not locked or has hit MAX_HOLD beats, and read data is
// routed back to the issuing master RD_LAT cycles after its beat.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  bus_arbiter_if.slave      bus
);

  logic [1:0] owner_r, owner_n;
  logic       last_winner_r, last_winner_n;
  logic [7:0] hold_cnt_r, hold_cnt_n;

  logic       own_id_s;
  logic       own_req_s;
  logic       own_lock_s;
  logic       other_req_s;
  logic [1:0] other_owner_s;
  logic       hold_cap_s;

  rd_tag_t    tag_in_s;
  rd_tag_t    tag_out_s;

  // Current owner's view of the request lines (only meaningful in OWN_M0/OWN_M1)
  assign own_id_s      = (owner_r == OWN_M1) ? MID_M1 : MID_M0;
  assign own_req_s     = (own_id_s == MID_M1) ? bus.m1_req  : bus.m0_req;
  assign own_lock_s    = (own_id_s == MID_M1) ? bus.m1_lock : bus.m0_lock;
  assign other_req_s   = (own_id_s == MID_M1) ? bus.m0_req  : bus.m1_req;
  assign other_owner_s = owner_of(~own_id_s);
  // The current beat would be the MAX_HOLD-th consecutive one against a waiting master
  assign hold_cap_s    = (({1'b0, hold_cnt_r} + 9'd1) == 9'(MAX_HOLD));

  // Owner state register, last winner and hold counter
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      owner_r       <= OWN_NONE;
      last_winner_r <= MID_M1;
      hold_cnt_r    <= 8'd0;
    end else begin
      owner_r       <= owner_n;
      last_winner_r <= last_winner_n;
      hold_cnt_r    <= hold_cnt_n;
    end
  end

  // Next owner: arbitration from idle, handover/release after each beat
  always_comb begin
    owner_n       = owner_r;
    last_winner_n = last_winner_r;
    hold_cnt_n    = hold_cnt_r;
    case (owner_r)
      OWN_NONE: begin
        hold_cnt_n = 8'd0;
        if (bus.m0_req && bus.m1_req) begin
          owner_n = (last_winner_r == MID_M0) ? OWN_M1 : OWN_M0;
        end else if (bus.m0_req) begin
          owner_n = OWN_M0;
        end else if (bus.m1_req) begin
          owner_n = OWN_M1;
        end else begin
          owner_n = OWN_NONE;
        end
      end
      OWN_M0, OWN_M1: begin
        if (own_req_s) begin
          // A beat happens this cycle
          if (other_req_s && (!own_lock_s || hold_cap_s)) begin
            owner_n       = other_owner_s;
            last_winner_n = own_id_s;
            hold_cnt_n    = 8'd0;
          end else if (other_req_s) begin
            hold_cnt_n = hold_cnt_r + 8'd1;
          end else begin
            hold_cnt_n = 8'd0;
          end
        end else begin
          // Owner went idle: pass to a waiting master or drop to idle
          owner_n       = other_req_s ? other_owner_s : OWN_NONE;
          last_winner_n = own_id_s;
          hold_cnt_n    = 8'd0;
        end
      end
      default: begin
        owner_n    = OWN_NONE;
        hold_cnt_n = 8'd0;
      end
    endcase
  end

  // Grants, bus mux and read tag launch for the current owner
  always_comb begin
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.Bus_addr  = 32'h0000_0000;
    bus.Bus_we    = 4'b0000;
    bus.Bus_wdata = 32'h0000_0000;
    tag_in_s      = TAG_IDLE;
    if (!cpu_rst) begin
      case (owner_r)
        OWN_M0: begin
          bus.m0_gnt = bus.m0_req;
          if (bus.m0_req) begin
            bus.Bus_addr   = bus.m0_addr;
            bus.Bus_we     = bus.m0_we;
            bus.Bus_wdata  = bus.m0_wdata;
            tag_in_s.valid = (bus.m0_we == 4'b0000);
            tag_in_s.id    = MID_M0;
          end else begin
            tag_in_s = TAG_IDLE;
          end
        end
        OWN_M1: begin
          bus.m1_gnt = bus.m1_req;
          if (bus.m1_req) begin
            bus.Bus_addr   = bus.m1_addr;
            bus.Bus_we     = bus.m1_we;
            bus.Bus_wdata  = bus.m1_wdata;
            tag_in_s.valid = (bus.m1_we == 4'b0000);
            tag_in_s.id    = MID_M1;
          end else begin
            tag_in_s = TAG_IDLE;
          end
        end
        default: begin
          tag_in_s = TAG_IDLE;
        end
      endcase
    end else begin
      tag_in_s = TAG_IDLE;
    end
  end

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_return_pipe (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  // Steer returning read data to the master named in the exiting tag
  always_comb begin
    bus.m0_rvalid = 1'b0;
    bus.m0_rdata  = 32'h0000_0000;
    bus.m1_rvalid = 1'b0;
    bus.m1_rdata  = 32'h0000_0000;
    if (!cpu_rst && tag_out_s.valid) begin
      if (tag_out_s.id == MID_M1) begin
        bus.m1_rvalid = 1'b1;
        bus.m1_rdata  = bus.Bus_rdata;
      end else begin
        bus.m0_rvalid = 1'b1;
        bus.m0_rdata  = bus.Bus_rdata;
      end
    end else begin
      bus.m0_rvalid = 1'b0;
    end
  end

endmodule
